// File: rtl/gasket_rx_align.sv
// gasket_rx_align
//   Packs a decoded 8b byte stream into 1/2/4-byte words, realigns on COM,
//   and queues completed words in a small show-ahead FIFO.
//
//   Optional feature macro: GASKET_SKP_DROP_EN
//     defined   : SKP K-symbols are removed from the stream (skp_drop pulses)
//     undefined : SKP bytes are packed as ordinary data, skp_drop = 0
//
// Ports
//   clk_to_get  in   sole clock, rising edge
//   Rst_n       in   asynchronous active-low reset
//   in_valid    in   Data_in / Rx_Datak valid
//   Data_in     in   [7:0] received byte
//   Rx_Datak    in   Data_in is a K-symbol
//   width_sel   in   [1:0] 0/3 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (clamped to MAX_BYTES)
//   out_ready   in   consumer takes the head word
//   out_valid   out  head word present
//   Data_out    out  [31:0] head word, byte 0 in [7:0], unused bytes 0
//   DataK_out   out  [3:0] per-byte K flags of the head word
//   fifo_level  out  occupied FIFO entries
//   overflow    out  sticky: a completed word was dropped on a full FIFO
//   align_err   out  pulse: a partial word was discarded by COM
//   skp_drop    out  pulse: a SKP byte was removed
module gasket_rx_align #(
  parameter int         MAX_BYTES  = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] COM_SYM    = 8'hBC,
  parameter logic [7:0] SKP_SYM    = 8'h1C
) (
  input  logic                          clk_to_get,
  input  logic                          Rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    Data_in,
  input  logic                          Rx_Datak,
  input  logic [1:0]                    width_sel,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [31:0]                   Data_out,
  output logic [3:0]                    DataK_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          align_err,
  output logic                          skp_drop
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [2:0] eff_width(input logic [1:0] sel);
    logic [2:0] w;
    case (sel)
      2'd1:    w = 3'd2;
      2'd2:    w = 3'd4;
      default: w = 3'd1;
    endcase
    if (w > 3'(MAX_BYTES)) w = 3'(MAX_BYTES);
    return w;
  endfunction

  logic [1:0]    width_q;
  logic [1:0]    cnt;
  logic [7:0]    lane_d [4];
  logic [3:0]    lane_k;

  logic [2:0]    nb;
  logic [1:0]    base;
  logic          wchg, is_com, is_skp, accept, push;
  logic [31:0]   word_d;
  logic [3:0]    word_k;

  logic [31:0]   mem_d [FIFO_DEPTH];
  logic [3:0]    mem_k [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [LW-1:0] level, level_after_pop, level_next;
  logic          pop, full, push_acc;

  always_comb begin
    nb     = eff_width(width_sel);
    wchg   = (width_sel != width_q);
    is_com = in_valid && Rx_Datak && (Data_in == COM_SYM);
`ifdef GASKET_SKP_DROP_EN
    is_skp = in_valid && Rx_Datak && (Data_in == SKP_SYM);
`else
    // SKP passes through as ordinary data
    is_skp = 1'b0 && (Data_in == SKP_SYM);
`endif
    // A width change or a COM restarts the word at lane 0; the incoming
    // byte is packed under the new alignment on the same edge.
    base   = (wchg || is_com) ? 2'd0 : cnt;
    accept = in_valid && !is_skp;
    push   = accept && ({1'b0, base} == nb - 3'd1);

    // Completed word: earlier lanes from registers, current byte merged in,
    // lanes at or above the effective width forced to zero.
    word_d = '0;
    word_k = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(nb)) begin
        if (i == int'(base)) begin
          word_d[i*8 +: 8] = Data_in;
          word_k[i]        = Rx_Datak;
        end else begin
          word_d[i*8 +: 8] = lane_d[i];
          word_k[i]        = lane_k[i];
        end
      end
    end

    pop             = out_valid && out_ready;
    full            = (level == LW'(FIFO_DEPTH));
    push_acc        = push && (!full || pop);
    level_after_pop = level - LW'(pop);
    level_next      = level_after_pop + LW'(push_acc);
    rd_next         = rd_ptr + PW'(pop);
  end

  always_ff @(posedge clk_to_get or negedge Rst_n) begin
    if (!Rst_n) begin
      width_q   <= '0;
      cnt       <= '0;
      lane_k    <= '0;
      for (int i = 0; i < 4; i++) lane_d[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      Data_out  <= '0;
      DataK_out <= '0;
      overflow  <= 1'b0;
      align_err <= 1'b0;
      skp_drop  <= 1'b0;
    end else begin
      width_q   <= width_sel;
      align_err <= is_com && !wchg && (cnt != 2'd0);
      skp_drop  <= is_skp;

      if (accept) begin
        lane_d[base] <= Data_in;
        lane_k[base] <= Rx_Datak;
        cnt          <= push ? 2'd0 : base + 2'd1;
      end else if (wchg) begin
        cnt <= 2'd0;
      end

      if (push && full && !pop) overflow <= 1'b1;
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr    <= rd_next;
      level     <= level_next;
      out_valid <= (level_next != '0);

      // Registered show-ahead head; holds its value while the FIFO is empty.
      if (level_next != '0) begin
        if (push_acc && level_after_pop == '0) begin
          Data_out  <= word_d;
          DataK_out <= word_k;
        end else begin
          Data_out  <= mem_d[rd_next];
          DataK_out <= mem_k[rd_next];
        end
      end
    end
  end

  always_ff @(posedge clk_to_get) begin
    if (push_acc) begin
      mem_d[wr_ptr] <= word_d;
      mem_k[wr_ptr] <= word_k;
    end
  end

  assign fifo_level = level;

endmodule
